// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// Start/done handshake; quotient and remainder are held until the next accepted start.
// Optional build macro DIV_SIGNED_EN: two's complement operands (magnitude divide,
// sign fix-up in the final state). Without it the divider is purely unsigned.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    // Partial remainder; its extra sign bit only exists inside one iteration, since a
    // restored value is always below the divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mdiv;
    logic             dbz_pend;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Operand magnitudes for the unsigned core
    always_comb begin
        op_a = dividend[WIDTH-1] ? -dividend : dividend;
        op_b = divisor[WIDTH-1] ? -divisor : divisor;
    end
`else
    // Unsigned core takes the operands as-is
    always_comb begin
        op_a = dividend;
        op_b = divisor;
    end
`endif

    // One restoring step: shift, trial subtract, keep or restore
    always_comb begin
        shifted = {acc, quo[WIDTH-1]};
        diff    = shifted - {1'b0, mdiv};
        if (diff[WIDTH]) begin
            acc_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end

    // Final result selection; on divide by zero quo holds the raw dividend
    always_comb begin
        if (dbz_pend) begin
            fin_q = '1;
            fin_r = quo;
        end else begin
`ifdef DIV_SIGNED_EN
            fin_q = neg_q ? -quo : quo;
            fin_r = neg_r ? -acc : acc;
`else
            fin_q = quo;
            fin_r = acc;
`endif
        end
    end

    // Control FSM with registered outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            cnt         <= '0;
            acc         <= '0;
            quo         <= '0;
            mdiv        <= '0;
            dbz_pend    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // The done cycle is spent in idle but must not accept a new start
                    if (start && !done) begin
                        mdiv <= op_b;
                        acc  <= '0;
`ifdef DIV_SIGNED_EN
                        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            quo      <= dividend;
                            dbz_pend <= 1'b1;
                            state    <= StFin;
                        end else begin
                            quo      <= op_a;
                            dbz_pend <= 1'b0;
                            cnt      <= CW'(WIDTH - 1);
                            busy     <= 1'b1;
                            state    <= StRun;
                        end
                    end
                end
                StRun: begin
                    acc <= acc_nxt;
                    quo <= quo_nxt;
                    if (cnt == '0) begin
                        state <= StFin;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                StFin: begin
                    quotient    <= fin_q;
                    remainder   <= fin_r;
                    div_by_zero <= dbz_pend;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider.
// Driver pushes expected results computed with plain arithmetic; a negedge monitor
// pops and compares whenever done is seen.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain division from the operand rules
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int at);
        exp_t e;
        e.at  = at;
        e.dbz = (b == 0);
        if (b == 0) begin
            e.q = '1;
            e.r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            longint sa;
            longint sd;
            sa  = longint'($signed(a));
            sd  = longint'($signed(b));
            e.q = W'(sa / sd);
            e.r = W'(sa % sd);
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 64'(quotient), 64'(e.q));
                check("remainder", 64'(remainder), 64'(e.r));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("done_latency_edge", 64'(edges), 64'(e.at));
                check("busy_low_at_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b, edges + 1 + ((b == 0) ? 1 : W + 1)));
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("busy_after_start", 64'(busy), 64'(b != 0));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 64'(done), 64'(1));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_q", 64'(quotient), 64'(0));
        check("reset_r", 64'(remainder), 64'(0));
        check("reset_dbz", 64'(div_by_zero), 64'(0));
        rst_n = 1'b1;

        // Directed cases
        issue(32'd100, 32'd7);               wait_done();
        issue(32'hFFFF_FFFF, 32'd1);         wait_done();
        issue(32'd5, 32'd9);                 wait_done();
        issue(32'd5, 32'd0);                 wait_done();
        issue(32'd8, 32'd2);                 wait_done();
        issue(32'hFFFF_FFF9, 32'd2);         wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF); wait_done();

        // Starts while busy must be ignored
        issue(32'd1000, 32'd13);
        repeat (2) @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        dividend = 32'd91;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Start coincident with done must be ignored
        issue(32'd50, 32'd5);
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!done) check("done_timeout", 64'(done), 64'(1));
        end
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done_ignored", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);

        // Reset mid-operation aborts at once
        issue(32'h1234_5678, 32'd3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_q", 64'(quotient), 64'(0));
        check("abort_r", 64'(remainder), 64'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd100, 32'd7);
        wait_done();

        // Randomized operands, including small and zero divisors
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            issue(a, b);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
